// File: rtl/mux_rr_nx1.sv
// N-channel, W-bit registered multiplexer with per-channel valid/ready handshakes,
// a one-deep output register and fixed-priority or round-robin arbitration.
module mux_rr_nx1 #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int SW   = 2,
  parameter int MODE = 1
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_sel,
  output logic            out_valid,
  input  logic            out_ready
);

  // Handshake: a word moves on any port only at a rising edge where that port's
  // valid and ready are both 1. Producers hold valid/data until they transfer;
  // in_ready depends only on in_valid, out_valid, out_ready and the rr pointer.

  logic [SW-1:0]  ptr;
  logic [SW-1:0]  start;
  logic [SW-1:0]  grant;
  logic [SW-1:0]  ptr_nxt;
  logic [W-1:0]   grant_data;
  logic [2*N-1:0] valid_dbl;
  logic [N-1:0]   valid_rot;
  logic [SW:0]    cand;
  logic           any_valid;
  logic           acc;
  logic           xfer_in;

  assign acc     = !out_valid || out_ready;
  assign start   = (MODE == 1) ? ptr : '0;
  assign xfer_in = acc && any_valid;

  // Rotate the request vector so that bit 0 is the channel at 'start'; the first
  // set bit then gives the winner's distance from the pointer.
  assign valid_dbl = {in_valid, in_valid} >> start;
  assign valid_rot = valid_dbl[N-1:0];

  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      if (!any_valid && valid_rot[k]) begin
        any_valid = 1'b1;
        cand      = {1'b0, start} + (SW+1)'(k);
        if (cand >= (SW+1)'(N)) begin
          cand = cand - (SW+1)'(N);
        end
        grant = cand[SW-1:0];
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SW'(i)) begin
        grant_data = in_data[i*W +: W];
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = xfer_in && (grant == SW'(i));
    end
  end

  // Explicit wrap so non-power-of-2 N never produces an out-of-range index.
  assign ptr_nxt = (grant == SW'(N-1)) ? '0 : grant + SW'(1);

  always_ff @(posedge clk) begin
    if (clr) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else begin
      if (xfer_in) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_sel   <= grant;
        if (MODE == 1) begin
          ptr <= ptr_nxt;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
